// File: rtl/mem_resp_pkg.sv
// Shared types and lane helpers for the memory responder.
// Lanes are little-endian: byte offset 0 is bits [7:0].
package mem_resp_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_HALF: r = {16'h0000, (off[1] ? word[31:16] : word[15:0])};
            SZ_BYTE: r = {24'h000000, word[{off, 3'b000} +: 8]};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_HALF: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            SZ_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM, one 32-bit word per entry, write and read share one address.
// Read data is registered (one-cycle latency); contents are not reset.
module ram_sp_sync #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] dout_q;

    // Read-before-write: dout shows the old word on a write cycle.
    always_ff @(posedge clock) begin
        if (we) mem[addr] <= din;
        dout_q <= mem[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/mem_responder.sv
// One-at-a-time load/store responder over a word RAM; sub-word stores use read-modify-write.
// Latency after accept: error 1, load 2, word store 2, sub-word store 3; no accept while a response is pending.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH_WORDS);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                accept;
    logic                req_err;
    logic                ram_we;
    logic [IDX_W-1:0]    ram_addr;
    logic [31:0]         ram_din;
    logic [31:0]         ram_dout;

    // busy_q marks a registered request still in IDLE awaiting its error decision.
    assign req_ready = reset && (state_q == IDLE) && !busy_q;
    assign accept    = req_valid && req_ready;

    assign req_err = (size_q == 2'b11)
                  || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
                  || ((size_q == SZ_HALF) && addr_q[0])
                  || (addr_q[ADDR_W-1:2] >= DEPTH_IDX);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            busy_d  = 1'b1;
            we_d    = req_we;
            size_d  = req_size;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    busy_d = 1'b0;
                    if (req_err)                          state_d = RESP;
                    else if (we_q && (size_q == SZ_WORD)) state_d = WR;
                    else                                  state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // In WR, ram_dout still holds the word fetched in RD, so the merge needs no extra register.
    assign ram_we   = (state_q == WR);
    assign ram_addr = addr_q[IDX_W+1:2];
    assign ram_din  = lane_merge(ram_dout, wdata_q, size_q, addr_q[1:0]);

    ram_sp_sync #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (IDX_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .din   (ram_din),
        .dout  (ram_dout)
    );

    // The address is frozen during RESP, so the registered read word stays stable.
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && req_err;
    assign resp_rdata = (resp_valid && !we_q && !req_err)
                      ? lane_extract(ram_dout, size_q, addr_q[1:0]) : 32'h0;

endmodule
